// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard logic.
//   md_state_e    : multi-cycle sequencer states
//   idex_ctrl_t   : ID/EX control-field bundle; a bubble loads IDEX_CTRL_BUBBLE
//   md_cnt_width  : down-counter width for a given multi-cycle latency
package pipeline_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam int unsigned ALUOP_W = 4;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } md_state_e;

    typedef struct packed {
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_write;
        logic               mem_read;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               reg_dst;
    } idex_ctrl_t;

    localparam int unsigned IDEX_CTRL_W = $bits(idex_ctrl_t);
    localparam idex_ctrl_t IDEX_CTRL_BUBBLE = '0;

    // ceil(log2(latency)), never less than 1
    function automatic int unsigned md_cnt_width(input int unsigned latency);
        int unsigned w;
        w = (latency > 1) ? $clog2(latency) : 1;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hazard_md_sequencer.sv
// Tracks a multi-cycle multiply/divide occupying EX.
//   clk, rst        : clock, async active-high reset
//   ex_md_start_i   : mul/div op entered EX this cycle
//   md_busy_o       : op occupies EX this cycle (combinational)
//   md_done_o       : last EX cycle of the op (combinational)
module hazard_md_sequencer
    import pipeline_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ex_md_start_i,
    output logic md_busy_o,
    output logic md_done_o
);

    localparam int unsigned CNT_W    = md_cnt_width(MD_LATENCY);
    localparam bit          MD_MULTI = (MD_LATENCY > 1);
    // Start cycle is spent in RUN, so MD_WAIT covers the remaining MD_LATENCY-1 cycles
    localparam int unsigned CNT_LOAD = MD_MULTI ? (MD_LATENCY - 2) : 0;

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        md_busy_o = 1'b0;
        md_done_o = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (MD_MULTI && ex_md_start_i) begin
                        md_busy_o = 1'b1;
                        state_d   = MD_WAIT;
                        cnt_d     = CNT_W'(CNT_LOAD);
                    end
                end
                MD_WAIT: begin
                    // Further starts are ignored while waiting
                    md_busy_o = 1'b1;
                    if (cnt_q == '0) begin
                        md_done_o = 1'b1;
                        state_d   = RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller beside the ID stage of the 5-stage pipeline.
//   clk, rst                 : clock, async active-high reset
//   id_rs, id_rt, id_uses_rt : source operands of the ID instruction
//   ex_mem_read, ex_rt       : load in EX and its destination
//   ex_md_start              : multi-cycle mul/div entered EX
//   branch_taken             : branch/jump resolved taken in ID
//   pc_write, ifid_write     : PC and IF/ID update enables
//   ifid_flush               : IF/ID loads a NOP
//   idex_hold, idex_bubble   : ID/EX retain / load zero control fields
//   md_busy, md_done         : multi-cycle op status
//   stall_cycles             : saturating count of cycles with pc_write=0
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MD_LATENCY  = 8,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_uses_rt,
    input  logic                   ex_mem_read,
    input  logic [REG_ADDR_W-1:0]  ex_rt,
    input  logic                   ex_md_start,
    input  logic                   branch_taken,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_hold,
    output logic                   idex_bubble,
    output logic                   md_busy,
    output logic                   md_done,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic                   load_use;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    hazard_md_sequencer #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_seq (
        .clk           (clk),
        .rst           (rst),
        .ex_md_start_i (ex_md_start),
        .md_busy_o     (md_busy),
        .md_done_o     (md_done)
    );

    // A load writing r0 never creates a real dependency
    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Pipeline-register control decode, highest priority first
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_hold   = 1'b0;
        idex_bubble = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (md_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_hold  = 1'b1;
        end else if (load_use) begin
            // Bubble makes EX MemRead=0 next cycle, so the stall lasts one cycle
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
        end
    end

    // Saturating stall statistics
    always_comb begin
        stall_d = stall_q;
        if (!pc_write && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, ex_md_start, branch_taken;

    logic        pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble, md_busy, md_done;
    logic [15:0] stall_cycles;
    logic        pc_write1, ifid_write1, ifid_flush1, idex_hold1, idex_bubble1, md_busy1, md_done1;
    logic [15:0] stall_cycles1;
    logic        pc_write_s, ifid_write_s, ifid_flush_s, idex_hold_s, idex_bubble_s, md_busy_s, md_done_s;
    logic [3:0]  stall_cycles_s;

    logic [6:0] ctl, ctl1;

    int total = 0;
    int bad   = 0;

    // {pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble, md_busy, md_done}
    localparam logic [6:0] C_RST = 7'b0010100;
    localparam logic [6:0] C_RUN = 7'b1100000;
    localparam logic [6:0] C_LU  = 7'b0000100;
    localparam logic [6:0] C_BR  = 7'b1110000;
    localparam logic [6:0] C_MD  = 7'b0001010;
    localparam logic [6:0] C_MDD = 7'b0001011;

    pipeline_hazard_ctrl #(.MD_LATENCY(8), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_md_start(ex_md_start),
        .branch_taken(branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_hold(idex_hold), .idex_bubble(idex_bubble),
        .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
    );

    pipeline_hazard_ctrl #(.MD_LATENCY(1), .STALL_CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_md_start(ex_md_start),
        .branch_taken(branch_taken), .pc_write(pc_write1), .ifid_write(ifid_write1),
        .ifid_flush(ifid_flush1), .idex_hold(idex_hold1), .idex_bubble(idex_bubble1),
        .md_busy(md_busy1), .md_done(md_done1), .stall_cycles(stall_cycles1)
    );

    pipeline_hazard_ctrl #(.MD_LATENCY(8), .STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_md_start(ex_md_start),
        .branch_taken(branch_taken), .pc_write(pc_write_s), .ifid_write(ifid_write_s),
        .ifid_flush(ifid_flush_s), .idex_hold(idex_hold_s), .idex_bubble(idex_bubble_s),
        .md_busy(md_busy_s), .md_done(md_done_s), .stall_cycles(stall_cycles_s)
    );

    assign ctl  = {pc_write, ifid_write, ifid_flush, idex_hold, idex_bubble, md_busy, md_done};
    assign ctl1 = {pc_write1, ifid_write1, ifid_flush1, idex_hold1, idex_bubble1, md_busy1, md_done1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One multiply/divide op; a second start in cycle 4 must be ignored
    task automatic run_md(input string tag);
        ex_md_start = 1'b1;
        #1 chk({tag, "_c1"}, 32'(ctl), 32'(C_MD));
        for (int k = 2; k <= 8; k++) begin
            tick();
            ex_md_start = (k == 4);
            #1 chk($sformatf("%s_c%0d", tag, k), 32'(ctl), 32'((k == 8) ? C_MDD : C_MD));
        end
        tick();
        ex_md_start = 1'b0;
        #1 chk({tag, "_after"}, 32'(ctl), 32'(C_RUN));
    endtask

    initial begin
        rst = 1'b0; id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_md_start = 1'b0; branch_taken = 1'b0;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1 chk("rst_ctl", 32'(ctl), 32'(C_RST));
        chk("rst_stall", 32'(stall_cycles), 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1 chk("rel_ctl", 32'(ctl), 32'(C_RUN));
        chk("rel_stall", 32'(stall_cycles), 32'd0);

        // Load-use on rs: one bubble then resume
        tick();
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        #1 chk("lu_rs", 32'(ctl), 32'(C_LU));
        tick();
        ex_mem_read = 1'b0;
        #1 chk("lu_resume", 32'(ctl), 32'(C_RUN));
        chk("lu_stall", 32'(stall_cycles), 32'd1);

        // r0 destination never stalls
        tick();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        #1 chk("lu_r0", 32'(ctl), 32'(C_RUN));

        // rt match only counts when rt is a source
        tick();
        ex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0;
        #1 chk("lu_rt_unused", 32'(ctl), 32'(C_RUN));
        id_uses_rt = 1'b1;
        #1 chk("lu_rt_used", 32'(ctl), 32'(C_LU));
        tick();
        ex_mem_read = 1'b0; id_uses_rt = 1'b0;
        #1 chk("lu_rt_stall", 32'(stall_cycles), 32'd2);

        // Taken branch alone flushes IF/ID
        branch_taken = 1'b1;
        #1 chk("br_only", 32'(ctl), 32'(C_BR));

        // Branch with load-use: stall first, flush next cycle
        tick();
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        #1 chk("br_lu_stall", 32'(ctl), 32'(C_LU));
        tick();
        ex_mem_read = 1'b0;
        #1 chk("br_lu_flush", 32'(ctl), 32'(C_BR));
        chk("br_lu_cnt", 32'(stall_cycles), 32'd3);
        tick();
        branch_taken = 1'b0;

        // Multi-cycle op; the latency-1 build ignores the start
        ex_md_start = 1'b1;
        #1 chk("md1_ctl", 32'(ctl1), 32'(C_RUN));
        run_md("md_a");
        chk("md_a_stall", 32'(stall_cycles), 32'd11);
        chk("md1_stall", 32'(stall_cycles1), 32'd3);
        chk("md1_idle", 32'(ctl1), 32'(C_RUN));
        chk("sat_pre", 32'(stall_cycles_s), 32'd11);

        // Second op: 19 stall cycles saturate the 4-bit counter
        tick();
        run_md("md_b");
        chk("md_b_stall", 32'(stall_cycles), 32'd19);
        chk("sat_15", 32'(stall_cycles_s), 32'd15);

        // Reset during cycle 4 of an op aborts it
        tick();
        ex_md_start = 1'b1;
        #1 chk("abort_c1", 32'(ctl), 32'(C_MD));
        tick(); ex_md_start = 1'b0;
        tick(); tick();
        #1 chk("abort_c4", 32'(ctl), 32'(C_MD));
        rst = 1'b1;
        #1 chk("abort_rst", 32'(ctl), 32'(C_RST));
        chk("abort_cnt", 32'(stall_cycles), 32'd0);
        tick();
        rst = 1'b0;
        #1 chk("abort_run", 32'(ctl), 32'(C_RUN));
        tick();
        run_md("md_c");
        chk("md_c_stall", 32'(stall_cycles), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
